div_seq: RTL

//   Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions. Counterpart of the

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the sequential divider.
// The pipeline side (master) drives operands and control. The divider (slave)
// returns busy/done and the HI/LO result.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             isSign;
    logic             start;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, isSign, start, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  a, b, isSign, start, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// It divides operand magnitudes, producing one quotient bit per cycle, MSB first.
// Signs are fixed up when the result is written: lo = quotient, hi = remainder.
// Optional feature macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// and finishes in one cycle. The result values match those of the full-latency path.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] dvd_q,      dvd_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q,      dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] rem_q,      rem_d;      // partial remainder
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Operand magnitudes. The most negative value wraps onto itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        abs_a = (bus.isSign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (bus.isSign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One restoring step: shift in the next dividend bit, then subtract when the divisor fits.
    // A clear borrow bit of the (WIDTH+1)-bit difference means rem_shift >= divisor.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[WIDTH];
        rem_step  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {dvd_q[WIDTH-2:0], q_bit};
    end

    // Next-state logic and datapath updates. Cancel overrides everything except reset.
    always_comb begin
        // NOTE: every _d starts as its _q, so no path through the case leaves a
        // variable unassigned. That keeps this block free of latches.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    dvd_d      = abs_a;
                    dvs_d      = abs_b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    sign_quo_d = bus.isSign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    sign_rem_d = bus.isSign & bus.a[WIDTH-1];
                    state_d    = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.b == '0) begin
                        state_d = DONE;
                        hi_d    = bus.a;
                        lo_d    = (bus.isSign && bus.a[WIDTH-1]) ? WIDTH'(1) : '1;
                    end
`else
                    // A zero divisor runs the full iteration: every step sets a
                    // quotient bit, and the dividend ends up as the remainder.
`endif
                end
            end
            CALC: begin
                dvd_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    lo_d    = sign_quo_q ? -quo_step : quo_step;
                    hi_d    = sign_rem_q ? -rem_step : rem_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here. Every flop samples the old
        // values, whatever order the statements are in.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // busy covers the accepting cycle combinationally, so the pipeline stalls at once.
    assign bus.busy = !rst && ((state_q == CALC) ||
                               ((state_q == IDLE) && bus.start && !bus.cancel));
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
